// File: rtl/ysyx_23060184_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU. It grants round-robin and
// allows one outstanding transaction; a watchdog ends any transaction the memory never answers.
module ysyx_23060184_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ifu_req_valid,
  output logic                      ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]     ifu_addr,
  output logic                      ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]     ifu_rdata,
  output logic                      ifu_resp_err,
  input  logic                      lsu_req_valid,
  output logic                      lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]     lsu_addr,
  input  logic                      lsu_wen,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
  output logic                      lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]     lsu_rdata,
  output logic                      lsu_resp_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_wen,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wmask,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_resp_err
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]              state_reg;
  logic                    owner_reg;
  logic                    last_grant_reg;
  logic [TW-1:0]           timer_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    wen_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] wmask_reg;

  logic                  any_req;
  logic                  pick_lsu;
  logic                  grant;
  logic                  busy;
  logic                  mem_done;
  logic                  timed_out;
  logic                  resp_fire;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  // On contention the requester that was not served last wins.
  assign any_req  = ifu_req_valid | lsu_req_valid;
  assign pick_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant_reg == OWN_IFU));
  assign grant    = (state_reg == IDLE) & any_req & ~rst;

  assign ifu_req_ready = grant & ~pick_lsu;
  assign lsu_req_ready = grant & pick_lsu;

  assign busy      = (state_reg == REQ) | (state_reg == RESP);
  assign mem_done  = (state_reg == RESP) & mem_resp_valid;
  // A genuine response arriving on the deadline cycle takes priority over the timeout.
  assign timed_out = WD_EN & busy & (timer_reg == T_LAST) & ~mem_done;
  assign resp_fire = mem_done | timed_out;
  assign resp_data = mem_done ? mem_rdata : '0;
  assign resp_err  = mem_done ? mem_resp_err : timed_out;

  assign ifu_resp_valid = resp_fire & (owner_reg == OWN_IFU);
  assign ifu_rdata      = ifu_resp_valid ? resp_data : '0;
  assign ifu_resp_err   = ifu_resp_valid & resp_err;
  assign lsu_resp_valid = resp_fire & (owner_reg == OWN_LSU);
  assign lsu_rdata      = lsu_resp_valid ? resp_data : '0;
  assign lsu_resp_err   = lsu_resp_valid & resp_err;

  assign mem_req_valid = (state_reg == REQ);
  assign mem_addr      = addr_reg;
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IFU;
      last_grant_reg <= OWN_LSU;
      timer_reg      <= '0;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= REQ;
            owner_reg <= pick_lsu;
            timer_reg <= '0;
            addr_reg  <= pick_lsu ? lsu_addr : ifu_addr;
            wen_reg   <= pick_lsu & lsu_wen;
            wdata_reg <= pick_lsu ? lsu_wdata : '0;
            wmask_reg <= pick_lsu ? lsu_wmask : '0;
          end
        end
        REQ: begin
          timer_reg <= timer_reg + TW'(1);
          if (timed_out) begin
            state_reg      <= IDLE;
            last_grant_reg <= owner_reg;
          end else if (mem_req_ready) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          timer_reg <= timer_reg + TW'(1);
          if (resp_fire) begin
            state_reg      <= IDLE;
            last_grant_reg <= owner_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios followed by a randomized run checked
// against a transaction-level model of the two requesters and the memory slave.
module tb_ysyx_23060184_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int vectors = 0;
  int miscompares = 0;

  logic [69:0]  mem_req;
  logic [33:0]  ifu_resp, lsu_resp;
  logic [139:0] all_out;
  assign mem_req  = {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};
  assign ifu_resp = {ifu_resp_valid, ifu_rdata, ifu_resp_err};
  assign lsu_resp = {lsu_resp_valid, lsu_rdata, lsu_resp_err};
  assign all_out  = {ifu_req_ready, ifu_resp, lsu_req_ready, lsu_resp, mem_req};

  ysyx_23060184_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1; mem_rdata = $urandom;
    #1;
    if (all_out !== '0) begin miscompares++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    vectors++;
    tick();
    if (all_out !== '0) begin miscompares++; $display("FAIL reset_held got=%h exp=0", all_out); end
    vectors++;
    clear_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_ifu_fetch;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL fetch_ready got=%b exp=10", {ifu_req_ready, lsu_req_ready});
    end
    vectors++;
    tick();
    ifu_req_valid = 0; ifu_addr = $urandom; mem_req_ready = 1;
    #1;
    if (mem_req !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
      miscompares++; $display("FAIL fetch_memreq got=%h exp=%h", mem_req, {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0});
    end
    vectors++;
    tick();
    mem_req_ready = 0;
    #1;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL fetch_wait got=%b exp=000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    vectors++;
    tick();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0413; mem_resp_err = 0;
    #1;
    if (ifu_resp !== {1'b1, 32'h0000_0413, 1'b0}) begin
      miscompares++; $display("FAIL fetch_resp got=%h exp=%h", ifu_resp, {1'b1, 32'h0000_0413, 1'b0});
    end
    vectors++;
    if ({lsu_req_ready, lsu_resp} !== 35'h0) begin
      miscompares++; $display("FAIL fetch_lsu_quiet got=%h exp=0", {lsu_req_ready, lsu_resp});
    end
    vectors++;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int nresp = 0;
    logic [3:0] order = '0;
    logic pend_resp = 0;
    do_reset();
    ifu_req_valid = 1; lsu_req_valid = 1;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      ifu_addr = $urandom; lsu_addr = $urandom;
      mem_req_ready = 1; mem_resp_valid = pend_resp; mem_rdata = $urandom;
      #1;
      if (ifu_req_ready && lsu_req_ready) begin
        miscompares++; $display("FAIL b2b_double_ready at cycle %0d", c);
      end
      if ((ifu_req_ready || lsu_req_ready) && n < 4) begin
        order[n] = lsu_req_ready;
        n++;
      end
      if (ifu_resp_valid || lsu_resp_valid) nresp++;
      pend_resp = mem_req_valid && mem_req_ready;
      tick();
    end
    clear_inputs();
    if (n !== 4) begin miscompares++; $display("FAIL b2b_grants got=%0d exp=4", n); end
    vectors++;
    if (order !== 4'b1010) begin miscompares++; $display("FAIL b2b_order got=%b exp=1010", order); end
    vectors++;
    if (nresp !== 4) begin miscompares++; $display("FAIL b2b_responses got=%0d exp=4", nresp); end
    vectors++;
    tick();
  endtask

  task automatic test_lsu_store;
    logic [31:0] rd;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    #1;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL store_ready got=%b exp=01", {ifu_req_ready, lsu_req_ready});
    end
    vectors++;
    tick();
    clear_inputs();
    mem_req_ready = 1;
    #1;
    if (mem_req !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
      miscompares++; $display("FAIL store_memreq got=%h exp=%h", mem_req, {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
    end
    vectors++;
    tick();
    rd = $urandom;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = rd; mem_resp_err = 0;
    #1;
    if (lsu_resp !== {1'b1, rd, 1'b0}) begin
      miscompares++; $display("FAIL store_resp got=%h exp=%h", lsu_resp, {1'b1, rd, 1'b0});
    end
    vectors++;
    if (ifu_resp !== 34'h0) begin miscompares++; $display("FAIL store_ifu_quiet got=%h exp=0", ifu_resp); end
    vectors++;
    tick();
    clear_inputs();
  endtask

  task automatic test_stall;
    logic [69:0] exp_l;
    logic [31:0] a, b, r;
    a = $urandom; b = $urandom;
    exp_l = {1'b1, a, 1'b1, 32'h1234_5678, 4'h5};
    lsu_req_valid = 1; lsu_addr = a; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h5;
    #1;
    if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_accept got=%b exp=1", lsu_req_ready); end
    vectors++;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      if (k >= 1) begin ifu_req_valid = 1; ifu_addr = b; end
      #1;
      if (mem_req !== exp_l) begin
        miscompares++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, mem_req, exp_l);
      end
      vectors++;
      if (ifu_req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ifu_ready k=%0d got=1 exp=0", k); end
      vectors++;
      tick();
    end
    r = $urandom;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = r; mem_resp_err = 1;
    #1;
    if ({ifu_req_ready, lsu_resp} !== {1'b0, 1'b1, r, 1'b1}) begin
      miscompares++; $display("FAIL stall_resp got=%h exp=%h", {ifu_req_ready, lsu_resp}, {1'b0, 1'b1, r, 1'b1});
    end
    vectors++;
    tick();
    mem_resp_valid = 0; mem_resp_err = 0;
    #1;
    if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ifu_grant got=%b exp=1", ifu_req_ready); end
    vectors++;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1;
    if (mem_req !== {1'b1, b, 1'b0, 32'h0, 4'h0}) begin
      miscompares++; $display("FAIL stall_ifu_memreq got=%h exp=%h", mem_req, {1'b1, b, 1'b0, 32'h0, 4'h0});
    end
    vectors++;
    tick();
    r = $urandom;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = r;
    #1;
    if (ifu_resp !== {1'b1, r, 1'b0}) begin
      miscompares++; $display("FAIL stall_ifu_resp got=%h exp=%h", ifu_resp, {1'b1, r, 1'b0});
    end
    vectors++;
    tick();
    clear_inputs();
  endtask

  // accept_at: cycle at which memory accepts the request (0 = never);
  // race: a genuine response arrives exactly on the deadline cycle.
  task automatic test_timeout(input int accept_at, input bit race);
    logic [33:0] exp_r;
    logic        exp_mv;
    ifu_req_valid = 1; ifu_addr = $urandom;
    #1;
    if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL to_accept got=%b exp=1", ifu_req_ready); end
    vectors++;
    for (int c = 1; c <= 10; c++) begin
      tick();
      clear_inputs();
      mem_req_ready = (c == accept_at);
      mem_rdata = $urandom | 32'h1;
      mem_resp_err = $urandom_range(0, 1);
      mem_resp_valid = (c == 8 && race) || (c == 10);
      #1;
      exp_mv = (c <= 8) && (accept_at == 0 || c <= accept_at);
      if (c == 8) exp_r = race ? {1'b1, mem_rdata, mem_resp_err} : {1'b1, 32'h0, 1'b1};
      else exp_r = '0;
      if (ifu_resp !== exp_r) begin
        miscompares++; $display("FAIL to_ifu_resp acc=%0d race=%0d c=%0d got=%h exp=%h", accept_at, race, c, ifu_resp, exp_r);
      end
      vectors++;
      if ({mem_req_valid, lsu_resp} !== {exp_mv, 34'h0}) begin
        miscompares++; $display("FAIL to_memvalid_lsu acc=%0d race=%0d c=%0d got=%h exp=%h", accept_at, race, c, {mem_req_valid, lsu_resp}, {exp_mv, 34'h0});
      end
      vectors++;
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_resp;
    ifu_req_valid = 1; ifu_addr = $urandom;
    #1;
    if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_accept got=%b exp=1", ifu_req_ready); end
    vectors++;
    tick();
    clear_inputs();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    if (ifu_resp !== 34'h0) begin miscompares++; $display("FAIL rstmid_pre got=%h exp=0", ifu_resp); end
    vectors++;
    rst = 1; mem_resp_valid = 1; mem_rdata = $urandom;
    #1;
    if (all_out !== '0) begin miscompares++; $display("FAIL rstmid_outputs got=%h exp=0", all_out); end
    vectors++;
    tick();
    if (all_out !== '0) begin miscompares++; $display("FAIL rstmid_held got=%h exp=0", all_out); end
    vectors++;
    rst = 0; mem_resp_valid = 0;
    #1;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL rstmid_regrant got=%b exp=10", {ifu_req_ready, lsu_req_ready});
    end
    vectors++;
    tick();
    clear_inputs();
  endtask

  task automatic test_random;
    bit          ifu_pend = 0, lsu_pend = 0, own = 0, last = 1, win_lsu;
    logic [31:0] ia = 0, la = 0, lwd = 0;
    logic        lw = 0;
    logic [3:0]  lm = 0;
    logic [69:0] exp_mem = '0;
    logic [33:0] exp_i, exp_l;
    logic [1:0]  exp_rdy;
    int          phase = 0, rcnt = 0, reqw = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ifu_pend && $urandom_range(0, 2) == 0) begin ifu_pend = 1; ia = $urandom; end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; la = $urandom; lw = $urandom_range(0, 1); lwd = $urandom; lm = 4'($urandom);
      end
      ifu_req_valid = ifu_pend; ifu_addr = ifu_pend ? ia : $urandom;
      lsu_req_valid = lsu_pend; lsu_addr = lsu_pend ? la : $urandom;
      lsu_wen = lsu_pend ? lw : 1'($urandom); lsu_wdata = lsu_pend ? lwd : $urandom;
      lsu_wmask = lsu_pend ? lm : 4'($urandom);
      mem_req_ready = (phase == 1 && reqw >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom; mem_resp_err = ($urandom_range(0, 5) == 0);
      mem_resp_valid = (phase == 2) ? (rcnt == 0) : ($urandom_range(0, 7) == 0);
      #1;
      win_lsu = lsu_pend && (!ifu_pend || last == 1'b0);
      exp_rdy = (phase == 0) ? {ifu_pend && !win_lsu, win_lsu} : 2'b00;
      if ({ifu_req_ready, lsu_req_ready} !== exp_rdy) begin
        miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {ifu_req_ready, lsu_req_ready}, exp_rdy);
      end
      vectors++;
      if (phase == 1) begin
        if (mem_req !== exp_mem) begin
          miscompares++; $display("FAIL rnd_memreq cyc=%0d got=%h exp=%h", cyc, mem_req, exp_mem);
        end
      end else if (mem_req_valid !== 1'b0) begin
        miscompares++; $display("FAIL rnd_memvalid cyc=%0d got=1 exp=0", cyc);
      end
      vectors++;
      exp_i = (phase == 2 && mem_resp_valid && !own) ? {1'b1, mem_rdata, mem_resp_err} : '0;
      exp_l = (phase == 2 && mem_resp_valid && own) ? {1'b1, mem_rdata, mem_resp_err} : '0;
      if ({ifu_resp, lsu_resp} !== {exp_i, exp_l}) begin
        miscompares++; $display("FAIL rnd_resp cyc=%0d got=%h exp=%h", cyc, {ifu_resp, lsu_resp}, {exp_i, exp_l});
      end
      vectors++;
      case (phase)
        0: if (exp_rdy != 2'b00) begin
          own = win_lsu;
          exp_mem = own ? {1'b1, la, lw, lwd, lm} : {1'b1, ia, 1'b0, 32'h0, 4'h0};
          if (own) lsu_pend = 0; else ifu_pend = 0;
          phase = 1; reqw = 0;
        end
        1: if (mem_req_ready) begin phase = 2; rcnt = $urandom_range(0, 2); end
           else reqw++;
        default: if (mem_resp_valid) begin phase = 0; last = own; end
                 else rcnt--;
      endcase
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_ifu_fetch();
    test_back_to_back();
    test_lsu_store();
    test_stall();
    test_timeout(0, 1'b0);
    test_timeout(3, 1'b0);
    test_timeout(7, 1'b1);
    test_reset_mid_resp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
